// File: rtl/coin_input_conditioner.sv
// ---------------------------------------------------------------------------
// coin_input_conditioner
//
// Front end of the turnstile datapath. It turns the raw board inputs into
// clean signals for the slow Moore controller:
//   - the coin-value switches are synchronized and latched into 'a' when an
//     insert is accepted;
//   - the insert pushbutton is synchronized, debounced and converted into
//     one 'flag' strobe per press. The strobe is stretched over HOLD_CYCLES
//     clk cycles so that the divided controller clock cannot miss it.
//
// Ports
//   clk      in   1  system clock (fast, undivided)
//   reset    in   1  asynchronous, active-high reset
//   coin_sw  in   4  raw coin-value switches (asynchronous to clk)
//   btn      in   1  raw insert pushbutton, active-high, bouncy
//   a        out  4  latched coin value
//   flag     out  1  event strobe, high for HOLD_CYCLES clk cycles per event
//   busy     out  1  high while an event is in progress (HOLD or WAIT_REL)
// ---------------------------------------------------------------------------
module coin_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] coin_sw,
    input  logic       btn,
    output logic [3:0] a,
    output logic       flag,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Clamp a parameter-derived limit into the counter range, so an oversized
    // parameter turns into a saturated limit instead of a truncated one.
    function automatic logic [CNT_W-1:0] clamp_cnt(input longint v);
        if (v <= 0)
            return '0;
        else if (v >= longint'(CNT_MAX))
            return CNT_MAX;
        else
            return CNT_W'(v);
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    localparam logic [CNT_W-1:0] DB_LIM    = clamp_cnt(longint'(DEBOUNCE_CYCLES));
    localparam logic [CNT_W-1:0] HOLD_LAST = clamp_cnt(longint'(HOLD_CYCLES) - 1);

    // Synchronizer stages
    logic             btn_meta_q,  btn_s_q;
    logic [3:0]       coin_meta_q, coin_s_q;
    // Debounce state
    logic             stable_q,    stable_d;
    logic             stable_prev_q;
    logic [CNT_W-1:0] db_cnt_q,    db_cnt_d;
    // Event FSM
    state_t           state_q,     state_d;
    logic [CNT_W-1:0] hold_cnt_q,  hold_cnt_d;
    logic [3:0]       a_q,         a_d;
    logic             flag_q,      flag_d;
    logic             busy_q,      busy_d;

    logic             stable_rise;

    // Debounce: the counter records how many consecutive edges btn_s has
    // disagreed with stable_btn; once that reaches DEBOUNCE_CYCLES the next
    // disagreeing edge adopts the new level.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        if (btn_s_q != stable_q) begin
            if (db_cnt_q >= DB_LIM) begin
                stable_d = btn_s_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = sat_inc(db_cnt_q);
            end
        end
    end

    assign stable_rise = stable_q & ~stable_prev_q;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        a_d        = a_q;
        unique case (state_q)
            IDLE: begin
                if (stable_rise) begin
                    if (coin_s_q != 4'd0) begin
                        state_d    = HOLD;
                        a_d        = coin_s_q;
                        hold_cnt_d = '0;
                    end else begin
                        // Zero-value insert: swallow the press without a strobe.
                        state_d = WAIT_REL;
                    end
                end
            end
            HOLD: begin
                // The pulse always runs to completion, even if the button
                // was already released; only the exit target depends on it.
                if (hold_cnt_q >= HOLD_LAST) begin
                    hold_cnt_d = '0;
                    state_d    = stable_q ? WAIT_REL : IDLE;
                end else begin
                    hold_cnt_d = sat_inc(hold_cnt_q);
                end
            end
            WAIT_REL: begin
                if (!stable_q)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        flag_d = (state_d == HOLD);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta_q    <= 1'b0;
            btn_s_q       <= 1'b0;
            coin_meta_q   <= 4'd0;
            coin_s_q      <= 4'd0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            db_cnt_q      <= '0;
            state_q       <= IDLE;
            hold_cnt_q    <= '0;
            a_q           <= 4'd0;
            flag_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            btn_meta_q    <= btn;
            btn_s_q       <= btn_meta_q;
            coin_meta_q   <= coin_sw;
            coin_s_q      <= coin_meta_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            db_cnt_q      <= db_cnt_d;
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            a_q           <= a_d;
            flag_q        <= flag_d;
            busy_q        <= busy_d;
        end
    end

    assign a    = a_q;
    assign flag = flag_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_coin_input_conditioner.sv
module tb_coin_input_conditioner;

    logic       clk;
    logic       reset;
    logic [3:0] coin_sw;
    logic       btn;
    logic [3:0] a;
    logic       flag;
    logic       busy;

    int checks = 0;
    int errors = 0;

    coin_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (4),
        .CNT_W          (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .coin_sw(coin_sw),
        .btn    (btn),
        .a      (a),
        .flag   (flag),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clk edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_edges(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Run n cycles and report how many flag pulses started and how many
    // cycles flag was high.
    task automatic count_flags(input int n, output int pulses, output int highs);
        logic prev;
        prev   = flag;
        pulses = 0;
        highs  = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (flag === 1'b1) highs++;
            if (flag === 1'b1 && prev !== 1'b1) pulses++;
            prev = flag;
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        btn     = 1'b0;
        coin_sw = 4'd0;
        wait_edges(3);
        checks++;
        if (a !== 4'd0 || flag !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: a=%0d flag=%b busy=%b, required a=0 flag=0 busy=0", a, flag, busy);
        end
        reset = 1'b0;
        wait_edges(2);
    endtask

    // Clean press with coin 5: flag after edge 7 through edge 10.
    task automatic test_basic_press();
        logic exp_flag;
        coin_sw = 4'd5;
        wait_edges(3);
        btn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            exp_flag = (k >= 7 && k <= 10);
            checks++;
            if (flag !== exp_flag) begin
                errors++;
                $display("FAIL basic_flag_edge%0d: flag=%b, required %b", k, flag, exp_flag);
            end
        end
        checks++;
        if (a !== 4'd5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_held: a=%0d busy=%b, required a=5 busy=1", a, busy);
        end
        // Release: stable falls at edge 6, FSM leaves WAIT_REL at edge 7.
        btn = 1'b0;
        for (int k = 0; k < 9; k++) begin
            step();
            checks++;
            if (busy !== (k < 7)) begin
                errors++;
                $display("FAIL basic_release_busy_edge%0d: busy=%b, required %b", k, busy, (k < 7));
            end
        end
    endtask

    task automatic test_chatter();
        int pulses, highs;
        for (int i = 0; i < 3; i++) begin
            btn = 1'b1;
            count_flags(2, pulses, highs);
            checks++;
            if (pulses !== 0 || highs !== 0) begin
                errors++;
                $display("FAIL chatter_high%0d: pulses=%0d, required 0", i, pulses);
            end
            btn = 1'b0;
            count_flags(2, pulses, highs);
            checks++;
            if (pulses !== 0 || highs !== 0) begin
                errors++;
                $display("FAIL chatter_low%0d: pulses=%0d, required 0", i, pulses);
            end
        end
        btn = 1'b1;
        count_flags(30, pulses, highs);
        checks++;
        if (pulses !== 1 || highs !== 4) begin
            errors++;
            $display("FAIL chatter_settle: pulses=%0d highs=%0d, required pulses=1 highs=4", pulses, highs);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL long_press_wait_rel: busy=%b, required 1", busy);
        end
        btn = 1'b0;
        wait_edges(12);
    endtask

    task automatic test_zero_coin();
        int pulses, highs;
        coin_sw = 4'd0;
        wait_edges(3);
        btn = 1'b1;
        count_flags(15, pulses, highs);
        checks++;
        if (pulses !== 0 || highs !== 0) begin
            errors++;
            $display("FAIL zero_coin_flag: highs=%0d, required 0", highs);
        end
        checks++;
        if (a !== 4'd5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_coin_state: a=%0d busy=%b, required a=5 busy=1", a, busy);
        end
        btn = 1'b0;
        wait_edges(12);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_coin_release: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_coin_change_in_hold();
        coin_sw = 4'd3;
        wait_edges(3);
        btn = 1'b1;
        wait_edges(8);
        checks++;
        if (flag !== 1'b1 || a !== 4'd3) begin
            errors++;
            $display("FAIL capture3: flag=%b a=%0d, required flag=1 a=3", flag, a);
        end
        coin_sw = 4'd9;
        wait_edges(10);
        checks++;
        if (a !== 4'd3) begin
            errors++;
            $display("FAIL coin_change_hold: a=%0d, required 3", a);
        end
        btn = 1'b0;
        wait_edges(12);
        checks++;
        if (a !== 4'd3) begin
            errors++;
            $display("FAIL coin_after_release: a=%0d, required 3", a);
        end
        btn = 1'b1;
        wait_edges(12);
        checks++;
        if (a !== 4'd9) begin
            errors++;
            $display("FAIL capture9: a=%0d, required 9", a);
        end
        btn = 1'b0;
        wait_edges(12);
    endtask

    task automatic test_release_in_hold();
        int pulses, highs;
        coin_sw = 4'd6;
        wait_edges(3);
        btn = 1'b1;
        wait_edges(8);   // flag went high at edge 7; one cycle into HOLD
        btn = 1'b0;
        count_flags(20, pulses, highs);
        // flag was already high for 1 cycle before counting started
        checks++;
        if (highs !== 3 || pulses !== 0) begin
            errors++;
            $display("FAIL release_hold_len: highs=%0d pulses=%0d, required highs=3 pulses=0", highs, pulses);
        end
        checks++;
        if (busy !== 1'b0 || flag !== 1'b0 || a !== 4'd6) begin
            errors++;
            $display("FAIL release_hold_idle: busy=%b flag=%b a=%0d, required busy=0 flag=0 a=6", busy, flag, a);
        end
        btn = 1'b1;
        count_flags(20, pulses, highs);
        checks++;
        if (pulses !== 1 || highs !== 4) begin
            errors++;
            $display("FAIL second_press: pulses=%0d highs=%0d, required pulses=1 highs=4", pulses, highs);
        end
        btn = 1'b0;
        wait_edges(12);
    endtask

    task automatic test_reset_midrun();
        coin_sw = 4'd7;
        wait_edges(3);
        btn = 1'b1;
        wait_edges(9);
        checks++;
        if (flag !== 1'b1 || busy !== 1'b1 || a !== 4'd7) begin
            errors++;
            $display("FAIL pre_reset_hold: flag=%b busy=%b a=%0d, required flag=1 busy=1 a=7", flag, busy, a);
        end
        #2;
        reset = 1'b1;
        #1;  // still well before the next clk edge
        checks++;
        if (a !== 4'd0 || flag !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: a=%0d flag=%b busy=%b, required a=0 flag=0 busy=0", a, flag, busy);
        end
        btn = 1'b0;
        wait_edges(2);
        reset = 1'b0;
        wait_edges(10);
        checks++;
        if (flag !== 1'b0 || busy !== 1'b0 || a !== 4'd0) begin
            errors++;
            $display("FAIL post_reset_idle: a=%0d flag=%b busy=%b, required a=0 flag=0 busy=0", a, flag, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic_press();
        test_chatter();
        test_zero_coin();
        test_coin_change_in_hold();
        test_release_in_hold();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
